// File: rtl/div_pkg.sv
// Shared definitions for the execute-stage restoring divider: FSM states,
// iteration count and the HI/LO split of the packed result.
package div_pkg;

    localparam int DIV_WIDTH  = 32;
    localparam int DIV_CYCLES = DIV_WIDTH;

    // result = {HI (remainder), LO (quotient)}
    localparam int LO_LSB = 0;
    localparam int LO_MSB = DIV_WIDTH - 1;
    localparam int HI_LSB = DIV_WIDTH;
    localparam int HI_MSB = 2 * DIV_WIDTH - 1;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_DIVZERO = 2'd1,
        ST_BUSY    = 2'd2,
        ST_DONE    = 2'd3
    } div_state_t;

endpackage

// File: rtl/divider.sv
// Multi-cycle radix-2 restoring divider for DIV/DIVU; stalls the pipeline
// while busy and drops out immediately on an exception flush.
module divider
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 signed_div,
    input  logic [WIDTH-1:0]     opdata1,
    input  logic [WIDTH-1:0]     opdata2,
    input  logic                 start,
    input  logic                 annul,
    output logic [2*WIDTH-1:0]   result,
    output logic                 ready,
    output logic                 div_stall,
    output logic [1:0]           dbg_state
);

    localparam int CW = $clog2(WIDTH) + 1;

    div_state_t         state, next_state;
    logic               sgn_q, neg1_q, neg2_q;
    logic [WIDTH-1:0]   divisor_q;
    logic [2*WIDTH:0]   work_q;
    logic [CW-1:0]      count_q;

    logic               accept;
    logic [WIDTH-1:0]   mag1, mag2;
    logic [2*WIDTH:0]   shifted, step;
    logic [WIDTH+1:0]   trial;
    logic [WIDTH-1:0]   quo, rem, quo_fix, rem_fix;

    // Handshake: start is a level held by E; it is accepted only in IDLE and
    // never in the ready cycle, so the finishing DIV is not taken twice.
    assign accept    = (state == ST_IDLE) && start && !annul && !ready;
    assign div_stall = start & ~ready & ~annul;
    assign dbg_state = state;

    assign mag1 = (signed_div && opdata1[WIDTH-1]) ? (~opdata1 + 1'b1) : opdata1;
    assign mag2 = (signed_div && opdata2[WIDTH-1]) ? (~opdata2 + 1'b1) : opdata2;

    // One restoring step: upper part holds the partial remainder.
    assign shifted = work_q << 1;
    assign trial   = {1'b0, shifted[2*WIDTH:WIDTH]} - {2'b00, divisor_q};
    assign step    = trial[WIDTH+1] ? shifted
                                    : {trial[WIDTH:0], shifted[WIDTH-1:1], 1'b1};

    assign quo     = work_q[WIDTH-1:0];
    assign rem     = work_q[2*WIDTH-1:WIDTH];
    assign quo_fix = (sgn_q && (neg1_q ^ neg2_q)) ? (~quo + 1'b1) : quo;
    assign rem_fix = (sgn_q && neg1_q) ? (~rem + 1'b1) : rem;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    next_state = (opdata2 == '0) ? ST_DIVZERO : ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (count_q == CW'(WIDTH - 1)) begin
                    next_state = ST_DONE;
                end
            end
            ST_DONE:    next_state = ST_IDLE;
            ST_DIVZERO: next_state = ST_IDLE;
            default:    next_state = ST_IDLE;
        endcase
        if (annul) begin
            next_state = ST_IDLE;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sgn_q     <= 1'b0;
            neg1_q    <= 1'b0;
            neg2_q    <= 1'b0;
            divisor_q <= '0;
            work_q    <= '0;
            count_q   <= '0;
            result    <= '0;
            ready     <= 1'b0;
        end else begin
            ready <= 1'b0;
            if (!annul) begin
                case (state)
                    ST_IDLE: begin
                        if (accept) begin
                            sgn_q     <= signed_div;
                            neg1_q    <= opdata1[WIDTH-1];
                            neg2_q    <= opdata2[WIDTH-1];
                            divisor_q <= mag2;
                            count_q   <= '0;
                            // A zero divisor keeps the raw dividend for HI.
                            work_q    <= (opdata2 == '0) ? {{(WIDTH+1){1'b0}}, opdata1}
                                                         : {{(WIDTH+1){1'b0}}, mag1};
                        end
                    end
                    ST_BUSY: begin
                        work_q  <= step;
                        count_q <= count_q + CW'(1);
                    end
                    ST_DONE: begin
                        result <= {rem_fix, quo_fix};
                        ready  <= 1'b1;
                    end
                    ST_DIVZERO: begin
                        result <= {work_q[WIDTH-1:0], {WIDTH{1'b1}}};
                        ready  <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_divider.sv
// Bench for the execute-stage divider: directed cases, annul, reset and
// randomized DIV/DIVU traffic against an arithmetic reference.
module tb_divider;
    import div_pkg::*;

    localparam int W = DIV_WIDTH;

    logic           clk = 1'b0;
    logic           resetn = 1'b0;
    logic           signed_div = 1'b0;
    logic [W-1:0]   opdata1 = '0;
    logic [W-1:0]   opdata2 = '0;
    logic           start = 1'b0;
    logic           annul = 1'b0;
    logic [2*W-1:0] result;
    logic           ready;
    logic           div_stall;
    logic [1:0]     dbg_state;

    logic [2*W-1:0] exp_q[$];
    logic [2*W-1:0] last_exp = '0;
    int             n_checks = 0;
    int             n_fail = 0;

    divider #(.WIDTH(W)) dut (
        .clk(clk), .resetn(resetn), .signed_div(signed_div),
        .opdata1(opdata1), .opdata2(opdata2), .start(start), .annul(annul),
        .result(result), .ready(ready), .div_stall(div_stall),
        .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // MIPS semantics: truncating division, remainder follows the dividend,
    // divide by zero gives {dividend, all ones}.
    function automatic logic [63:0] ref_div(input logic sgn, input logic [31:0] a,
                                            input logic [31:0] b);
        longint sa, sb, q, r;
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        if (!sgn) begin
            sa = longint'({32'd0, a});
            sb = longint'({32'd0, b});
        end else begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
        end
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
    endfunction

    // Called just after a rising edge; cycle 0 is the cycle start rises in.
    task automatic run_div(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                           input bit hold);
        int  cyc;
        bit  seen;
        int  exp_lat;
        signed_div = sgn;
        opdata1    = a;
        opdata2    = b;
        start      = 1'b1;
        exp_q.push_back(ref_div(sgn, a, b));
        exp_lat = (b == 32'd0) ? 2 : W + 2;
        cyc  = 0;
        seen = 0;
        while (!seen && cyc < 100) begin
            @(negedge clk);
            if (ready) begin
                seen = 1;
            end else begin
                check("stall_busy", 64'(div_stall), 64'd1);
                @(posedge clk);
                #1;
                cyc++;
            end
        end
        check("latency", 64'(cyc), 64'(exp_lat));
        last_exp = exp_q.pop_front();
        if (seen) begin
            check("result", result, last_exp);
            check("stall_ready", 64'(div_stall), 64'd0);
        end
        @(posedge clk);
        #1;
        if (!hold) begin
            start = 1'b0;
            @(negedge clk);
            check("ready_pulse", 64'(ready), 64'd0);
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        int  readies;
        logic [31:0] a, b;
        logic        sgn;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_result", result, 64'd0);
        check("rst_ready", 64'(ready), 64'd0);
        check("rst_stall", 64'(div_stall), 64'd0);
        check("rst_state", 64'(dbg_state), 64'(ST_IDLE));
        resetn = 1'b1;
        @(posedge clk);
        #1;

        // Directed cases
        run_div(1'b0, 32'd100, 32'd7, 0);
        run_div(1'b1, -32'sd7, 32'd2, 0);
        run_div(1'b1, 32'd7, -32'sd2, 0);
        run_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        run_div(1'b0, 32'd5, 32'd0, 0);
        run_div(1'b1, 32'hFFFF_FFF0, 32'd0, 0);

        // Annul during BUSY iteration 10: no write, previous result kept
        signed_div = 1'b0;
        opdata1    = 32'd1000;
        opdata2    = 32'd3;
        start      = 1'b1;
        repeat (10) begin
            @(posedge clk);
            #1;
        end
        check("pre_annul_state", 64'(dbg_state), 64'(ST_BUSY));
        annul = 1'b1;
        #1;
        check("annul_stall", 64'(div_stall), 64'd0);
        @(posedge clk);
        #1;
        annul = 1'b0;
        start = 1'b0;
        @(negedge clk);
        check("annul_state", 64'(dbg_state), 64'(ST_IDLE));
        readies = 0;
        repeat (40) begin
            @(negedge clk);
            if (ready) readies++;
        end
        check("annul_no_ready", 64'(readies), 64'd0);
        check("annul_keep", result, last_exp);
        @(posedge clk);
        #1;

        // Back-to-back: second DIV presented the cycle after ready
        run_div(1'b0, 32'hFFFF_FFFF, 32'd1, 1);
        run_div(1'b1, -32'sd9, 32'd4, 0);

        // Randomized traffic
        for (int i = 0; i < 24; i++) begin
            sgn = 1'($urandom_range(0, 1));
            a   = $urandom;
            case ($urandom_range(0, 7))
                0:       b = 32'd0;
                1, 2:    b = 32'($urandom_range(1, 15));
                3:       b = -32'($urandom_range(1, 15));
                4:       b = 32'hFFFF_FFFF;
                default: b = $urandom;
            endcase
            if ($urandom_range(0, 5) == 0) a = 32'h8000_0000;
            run_div(sgn, a, b, bit'($urandom_range(0, 1)));
        end
        start = 1'b0;
        @(posedge clk);
        #1;

        // Asynchronous reset mid-BUSY, then a fresh divide
        signed_div = 1'b0;
        opdata1    = 32'd12345;
        opdata2    = 32'd67;
        start      = 1'b1;
        repeat (6) @(posedge clk);
        @(negedge clk);
        #2;
        resetn = 1'b0;
        start  = 1'b0;
        #1;
        check("arst_result", result, 64'd0);
        check("arst_ready", 64'(ready), 64'd0);
        check("arst_stall", 64'(div_stall), 64'd0);
        check("arst_state", 64'(dbg_state), 64'(ST_IDLE));
        @(negedge clk);
        resetn = 1'b1;
        @(posedge clk);
        #1;
        run_div(1'b1, -32'sd12345, 32'd67, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
